disk_point_buffer: RTL and testbench

- Downstream stage of the disk sequence generator.
- Requests points from the generator with one-cycle `pop_enable` pulses and captures each (`disk_x`, `disk_y`) pair on the generator's `valid` pulse.
- Stores the pairs in a small FIFO and presents them to the consumer over a ready/valid handshake.
- Keeps the FIFO prefetched so the consumer sees back-to-back points despite the generator's multi-cycle latency.

---
 rtl/disk_point_buffer.sv | 166 ++++++++++++++++
 tb/tb_disk_point_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/disk_point_buffer.sv
// Prefetching point FIFO between the disk sequence generator and its consumer.
// Keeps at most one generator request in flight and presents points over ready/valid.
`timescale 1ns/1ps
module disk_point_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  output logic              gen_pop,
  input  logic [DATA_W-1:0] gen_x,
  input  logic [DATA_W-1:0] gen_y,
  input  logic              gen_valid,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic [31:0]       delivered,
  output logic              overrun
);

  typedef enum logic [1:0] {
    REQ_IDLE    = 2'd0,
    REQ_WAIT    = 2'd1,
    REQ_DISCARD = 2'd2
  } req_state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  req_state_t              r_state;
  req_state_t              w_state_nxt;
  logic [2*DATA_W-1:0]     r_mem [DEPTH];
  logic [ADDR_W-1:0]       r_wr_ptr;
  logic [ADDR_W-1:0]       r_rd_ptr;
  logic [ADDR_W-1:0]       w_wr_ptr_nxt;
  logic [ADDR_W-1:0]       w_rd_ptr_nxt;
  logic [ADDR_W:0]         r_level;
  logic [ADDR_W:0]         w_level_nxt;
  logic [DATA_W-1:0]       r_out_x;
  logic [DATA_W-1:0]       r_out_y;
  logic [2*DATA_W-1:0]     w_head;
  logic [31:0]             r_delivered;
  logic                    r_overrun;
  logic                    r_gen_pop;
  logic                    w_issue;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_spurious;

  // Request FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REQ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      REQ_IDLE:    w_state_nxt = w_issue ? REQ_WAIT : REQ_IDLE;
      REQ_WAIT: begin
        if (gen_valid) begin
          w_state_nxt = REQ_IDLE;
        end else if (flush) begin
          w_state_nxt = REQ_DISCARD;
        end else begin
          w_state_nxt = REQ_WAIT;
        end
      end
      REQ_DISCARD: w_state_nxt = gen_valid ? REQ_IDLE : REQ_DISCARD;
      default:     w_state_nxt = REQ_IDLE;
    endcase
  end

  // Request FSM outputs; a read on this edge frees a slot so a full FIFO can re-request at once
  always_comb begin
    w_issue    = 1'b0;
    w_wr       = 1'b0;
    w_spurious = 1'b0;
    w_rd       = (r_level != '0) && out_ready && !flush;
    case (r_state)
      REQ_IDLE: begin
        w_issue    = enable && !flush && ((r_level < LP_DEPTH) || w_rd);
        w_spurious = gen_valid;
      end
      REQ_WAIT:    w_wr = gen_valid && !flush;
      REQ_DISCARD: w_wr = 1'b0;
      default:     w_wr = 1'b0;
    endcase
  end

  // Pointer, occupancy and head-of-queue next values; bypass when the new point becomes the head
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;
    if (flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_level_nxt  = '0;
    end else begin
      w_wr_ptr_nxt = w_wr ? r_wr_ptr + ADDR_W'(1) : r_wr_ptr;
      w_rd_ptr_nxt = w_rd ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;
      case ({w_wr, w_rd})
        2'b10:   w_level_nxt = r_level + (ADDR_W+1)'(1);
        2'b01:   w_level_nxt = r_level - (ADDR_W+1)'(1);
        default: w_level_nxt = r_level;
      endcase
    end
    if (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head = {gen_x, gen_y};
    end else begin
      w_head = r_mem[w_rd_ptr_nxt];
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {gen_x, gen_y};
    end
  end

  // Pointers, counters, flags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_delivered <= 32'd0;
      r_overrun   <= 1'b0;
      r_gen_pop   <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_level   <= w_level_nxt;
      r_out_x   <= w_head[2*DATA_W-1:DATA_W];
      r_out_y   <= w_head[DATA_W-1:0];
      r_gen_pop <= w_issue;
      if (w_rd) begin
        r_delivered <= r_delivered + 32'd1;
      end
      if (w_spurious) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign gen_pop   = r_gen_pop;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_valid = (r_level != '0);
  assign level     = r_level;
  assign delivered = r_delivered;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_disk_point_buffer.sv
// Scoreboard bench for disk_point_buffer: a generator model answers pops after a latency,
// a reference queue holds the points the consumer should see, and a monitor checks every cycle.
`timescale 1ns/1ps
module tb_disk_point_buffer;
  localparam int DEPTH = 8, ADDR_W = 3, DATA_W = 32;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, flush = 1'b0;
  logic gen_valid = 1'b0, out_ready = 1'b0;
  logic [DATA_W-1:0] gen_x = '0, gen_y = '0;
  logic gen_pop, out_valid, overrun;
  logic [DATA_W-1:0] out_x, out_y;
  logic [ADDR_W:0] level;
  logic [31:0] delivered;

  disk_point_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .gen_pop(gen_pop),
    .gen_x(gen_x), .gen_y(gen_y), .gen_valid(gen_valid), .out_x(out_x), .out_y(out_y),
    .out_valid(out_valid), .out_ready(out_ready), .level(level), .delivered(delivered),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  logic [63:0] exp_q[$];
  int gen_sched[$];
  int cyc = 0, outstanding = 0, pops = 0, k = 0, lat = 7, exp_delivered = 0;
  bit req_flushed = 0, exp_overrun = 0, override = 0, inject = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: tracks the outstanding request and which returned points get stored
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (gen_valid) begin
        if (outstanding == 0) exp_overrun = 1'b1;
        else begin
          if (!req_flushed && !flush) exp_q.push_back({gen_x, gen_y});
          outstanding = 0;
          req_flushed = 1'b0;
        end
      end
      if (flush) begin
        exp_q.delete();
        if (outstanding != 0) req_flushed = 1'b1;
      end
      if (gen_pop) begin
        chk("single_outstanding", 64'(outstanding), 64'd0);
        outstanding = 1;
        req_flushed = 1'b0;
        pops++;
        gen_sched.push_back(cyc + lat - 1);
      end
    end
  end

  // Generator model: answers each pop after the latency, or injects a spurious valid
  initial forever begin
    @(posedge clk);
    #1;
    gen_valid = 1'b0;
    if (gen_sched.size() > 0 && gen_sched[0] == cyc) begin
      void'(gen_sched.pop_front());
      gen_valid = 1'b1;
      if (override) begin
        gen_x = 32'hDEAD; gen_y = 32'hBEEF; override = 1'b0;
      end else begin
        k++;
        gen_x = 32'(k); gen_y = 32'(1000 + k);
      end
    end else if (inject) begin
      inject = 1'b0;
      gen_valid = 1'b1;
      gen_x = $urandom; gen_y = $urandom;
    end
  end

  // Monitor: compares status each cycle and pops the scoreboard on each handshake
  logic stall_v = 1'b0;
  logic [63:0] stall_d = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) stall_v = 1'b0;
    else begin
      chk("level", 64'(level), 64'(exp_q.size()));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("overrun", 64'(overrun), 64'(exp_overrun));
      chk("delivered", 64'(delivered), 64'(exp_delivered));
      if (stall_v && out_valid) chk("hold_stable", {out_x, out_y}, stall_d);
      stall_v = out_valid && !out_ready && !flush;
      stall_d = {out_x, out_y};
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) chk("unexpected_xfer", 64'd1, 64'd0);
        else chk("xfer_data", {out_x, out_y}, exp_q.pop_front());
        exp_delivered++;
      end
    end
  end

  task automatic wait_level(input int target, input int budget);
    int n = 0;
    while (level !== (ADDR_W+1)'(target) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_level", 64'(level), 64'(target));
  endtask

  task automatic wait_pop(input int budget);
    int n = 0;
    while (gen_pop !== 1'b1 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_pop", 64'(gen_pop), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gen_pop", 64'(gen_pop), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_xy", {out_x, out_y}, 64'd0);
    rst_n = 1'b1;

    // Prefetch fill with the consumer stalled
    enable = 1'b1;
    wait_level(8, 300);
    repeat (20) begin
      @(posedge clk); #1;
      chk("no_pop_when_full", 64'(gen_pop), 64'd0);
    end
    chk("fill_pops", 64'(pops), 64'd8);

    // Ordering under random backpressure and random latency, 20 points total
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      lat = $urandom_range(2, 9);
      enable = (pops < 20);
      if (exp_delivered == 20 && outstanding == 0) break;
    end
    out_ready = 1'b0; enable = 1'b0; lat = 7;
    chk("delivered_20", 64'(delivered), 64'd20);
    chk("pops_20", 64'(pops), 64'd20);

    // Full FIFO, single read frees a slot and re-requests in the next cycle
    enable = 1'b1;
    wait_level(8, 300);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("full_read_level", 64'(level), 64'd7);
    chk("full_read_pop", 64'(gen_pop), 64'd1);
    wait_level(8, 50);
    enable = 1'b0; out_ready = 1'b1;
    wait_level(0, 50);
    out_ready = 1'b0;

    // Flush while a request is in flight
    repeat (3) @(posedge clk);
    #1 override = 1'b1; enable = 1'b1;
    wait_pop(20);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("flush_point_returned", 64'(override), 64'd0);
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_overrun", 64'(overrun), 64'd0);
    enable = 1'b1;
    wait_pop(20);
    enable = 1'b0;
    wait_level(1, 20);
    out_ready = 1'b1;
    wait_level(0, 10);
    out_ready = 1'b0;

    // Spurious valid with nothing outstanding
    inject = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("spurious_overrun", 64'(overrun), 64'd1);
    chk("spurious_level", 64'(level), 64'd0);

    // Asynchronous reset while waiting on a request with five entries buffered
    enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (level == 4'd5 && outstanding == 1) break;
    end
    chk("pre_reset_level", 64'(level), 64'd5);
    @(negedge clk); #2;
    rst_n = 1'b0; enable = 1'b0;
    #1;
    chk("async_rst_outputs", {59'd0, gen_pop, out_valid, overrun, 2'b00} | 64'(level), 64'd0);
    chk("async_rst_delivered", 64'(delivered), 64'd0);
    chk("async_rst_xy", {out_x, out_y}, 64'd0);
    exp_q.delete(); outstanding = 0; req_flushed = 1'b0;
    exp_overrun = 1'b0; exp_delivered = 0;
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("stale_valid_overrun", 64'(overrun), 64'd1);
    chk("stale_valid_level", 64'(level), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
